// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory read port plus the
// valid/ready instruction channel towards the execute stage.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir_data;
  logic [ADDR_W-1:0]  ir_pc;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
    input  imem_rvalid, imem_rdata, ir_ready
  );

  // memory / execute stage side
  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_data, ir_pc,
    output imem_rvalid, imem_rdata, ir_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory read in
// flight, buffers returned words and hands them to the execute stage.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no request outstanding; issue one when enabled and a slot is free
// S_REQ  | request outstanding, its data will be buffered
// S_DROP | request outstanding from before a redirect, its data is discarded
// S_HALT | HLT opcode fetched; idle until a redirect
module instr_fetch_unit #(
  parameter int               ADDR_W     = 16,
  parameter int               INSTR_W    = 32,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [4:0]       HLT_OP     = 5'h1F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                halted,
  instr_fetch_unit_if.master  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HALT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [INSTR_W-1:0] buf_data_q [FIFO_DEPTH];
  logic [INSTR_W-1:0] buf_data_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]  buf_pc_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0]  buf_pc_d   [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               is_hlt;
  logic [CNT_W-1:0]   post_cnt;

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.ir_valid  = (cnt_q != '0);
  assign bus.ir_data   = buf_data_q[rd_ptr_q];
  assign bus.ir_pc     = buf_pc_q[rd_ptr_q];
  assign halted        = halted_q;

  // Next-state, request generation and instruction buffer update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    push       = 1'b0;
    pop        = (cnt_q != '0) && bus.ir_ready;
    is_hlt     = (bus.imem_rdata[INSTR_W-1 -: 5] == HLT_OP);
    // occupancy after this cycle's push and pop; the new request reserves a slot
    post_cnt   = cnt_q + CNT_W'(1) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (fetch_en && (cnt_q < DEPTH_C)) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.imem_rvalid) begin
          push = 1'b1;
          pc_d = pc_q + ADDR_W'(1);
          if (is_hlt) begin
            req_d    = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (fetch_en && (post_cnt < DEPTH_C)) begin
            addr_d = pc_q + ADDR_W'(1);
          end else begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (redirect) begin
      push     = 1'b0;
      pop      = 1'b0;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      // an in-flight read cannot be cancelled, so keep presenting it and drop its data
      if (req_q && !bus.imem_rvalid) begin
        req_d   = 1'b1;
        addr_d  = addr_q;
        state_d = S_DROP;
      end else begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    end

    if (push) begin
      buf_data_d[wr_ptr_q] = bus.imem_rdata;
      buf_pc_d[wr_ptr_q]   = addr_q;
    end

    if (redirect) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end
  end

  // State, PC, request and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule
